// File: rtl/riscv_pkg.sv
// riscv_pkg: fetch constants, the queued instruction-pair record and
// a PC word-alignment helper shared by the fetch unit and its queue.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int          FETCH_QUEUE_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr_a;
        logic [31:0] instr_b;
    } fetch_pair_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO of fetched instruction pairs; flush wins over
// push/pop and the head reads as zero while the queue is empty.
module fetch_queue
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  fetch_pair_t push_data_i,
    output fetch_pair_t head_o,
    output logic [1:0]  count_o
);

    localparam int PW = $clog2(FETCH_QUEUE_DEPTH);

    fetch_pair_t     mem_q [FETCH_QUEUE_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]      count_q, count_d;

    always_comb begin
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + PW'(pop_i);
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + PW'(push_i);
        count_d  = flush_i ? '0 : count_q + 2'(push_i) - 2'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i)
            mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/dual_fetch_unit.sv
// dual_fetch_unit: two-wide instruction fetch over a 1-cycle sync memory.
// Define FETCH_PERF_EN to build the pair/stall performance counters.
module dual_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_a,
    output logic [31:0] imem_addr_b,
    input  logic [31:0] imem_data_a,
    input  logic [31:0] imem_data_b,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr_a,
    output logic [31:0] out_instr_b,
    output logic [31:0] perf_pairs,
    output logic [31:0] perf_stalls
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  count;
    logic [2:0]  occupancy;
    logic        pop, push, issue;
    fetch_pair_t head, push_pair;

    assign imem_addr_a = redirect_valid ? word_align(redirect_pc) : pc_q;
    assign imem_addr_b = imem_addr_a + 32'd4;

    assign out_valid = count != 2'd0;
    assign pop       = out_valid & out_ready & ~redirect_valid;
    // A redirect kills whatever response lands this cycle.
    assign push      = inflight_q & ~redirect_valid;

    // Queued plus in-flight pairs after this cycle's pop; issuing only below
    // the queue depth is what keeps the FIFO from ever overflowing.
    assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = redirect_valid | (occupancy < 3'(FETCH_QUEUE_DEPTH));

    always_comb begin
        pc_d       = issue ? imem_addr_a + 32'd8 : pc_q;
        req_pc_d   = issue ? imem_addr_a : req_pc_q;
        inflight_d = issue;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign push_pair.pc      = req_pc_q;
    assign push_pair.instr_a = imem_data_a;
    assign push_pair.instr_b = imem_data_b;

    fetch_queue u_fetch_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .push_data_i (push_pair),
        .head_o      (head),
        .count_o     (count)
    );

    assign out_pc      = head.pc;
    assign out_instr_a = head.instr_a;
    assign out_instr_b = head.instr_b;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_pairs_q, perf_stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_pairs_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_pairs_q  <= perf_pairs_q + 32'(pop);
            perf_stalls_q <= perf_stalls_q + 32'(out_valid & ~out_ready);
        end
    end

    assign perf_pairs  = perf_pairs_q;
    assign perf_stalls = perf_stalls_q;
`else
    assign perf_pairs  = '0;
    assign perf_stalls = '0;
`endif

endmodule
